// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, reads a one-cycle-latency program ROM
// and hands words to the core over a valid/ready handshake, with jump and halt.
module inst_fetch #(
    parameter int             N         = 16,
    parameter int             AW        = 8,
    parameter logic [AW-1:0]  RESET_PC  = '0,
    parameter logic [N-1:0]   HALT_INST = 16'hFFFF
) (
    input  logic          clk,
    input  logic          rst,
    output logic [AW-1:0] mem_addr,
    input  logic [N-1:0]  mem_data,
    output logic [N-1:0]  inst,
    output logic          inst_valid,
    input  logic          inst_ready,
    output logic [AW-1:0] pc,
    input  logic          jmp,
    input  logic [AW-1:0] jmp_addr,
    output logic          halted
);

    typedef enum logic [1:0] {
        S_FILL = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] nxt_q, nxt_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [N-1:0]  inst_q, inst_d;
    logic          capture;

    // nxt_q always names the address whose word is currently on mem_data,
    // so mem_addr defaults to it and the ROM keeps re-reading the same word.
    always_comb begin
        state_d  = state_q;
        nxt_d    = nxt_q;
        pc_d     = pc_q;
        inst_d   = inst_q;
        mem_addr = nxt_q;
        capture  = (state_q == S_FILL) || ((state_q == S_RUN) && inst_ready);

        if (rst) begin
            mem_addr = RESET_PC;
        end else if (jmp) begin
            mem_addr = jmp_addr;
            nxt_d    = jmp_addr;
            state_d  = S_FILL;
        end else if (capture) begin
            if (mem_data == HALT_INST) begin
                state_d = S_HALT;
            end else begin
                inst_d   = mem_data;
                pc_d     = nxt_q;
                nxt_d    = nxt_q + 1'b1;
                mem_addr = nxt_q + 1'b1;
                state_d  = S_RUN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FILL;
            nxt_q   <= RESET_PC;
            pc_q    <= RESET_PC;
            inst_q  <= '0;
        end else begin
            state_q <= state_d;
            nxt_q   <= nxt_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
        end
    end

    // Valid and halted are pure decodes of the registered state.
    assign inst       = inst_q;
    assign pc         = pc_q;
    assign inst_valid = (state_q == S_RUN);
    assign halted     = (state_q == S_HALT);

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed program scenarios plus random ready/jump/reset
// traffic checked against a stream-level model of which ROM word is presented.
module tb_inst_fetch;

    localparam logic [15:0] H   = 16'hFFFF;
    localparam logic [7:0]  RST = 8'd0;

    logic        clk = 1'b0;
    logic        rst = 1'b1, jmp = 1'b0, inst_ready = 1'b0;
    logic [7:0]  jmp_addr = '0;
    logic [7:0]  mem_addr, pc;
    logic [15:0] mem_data, inst;
    logic        inst_valid, halted;

    logic        rst2 = 1'b1;
    logic [7:0]  mem_addr2, pc2;
    logic [15:0] mem_data2, inst2;
    logic        inst_valid2, halted2;

    logic [15:0] rom  [256];
    logic [15:0] rom2 [256];

    int n_checks = 0;
    int n_fail   = 0;
    bit armed    = 0;
    bit verbose  = 0;

    // Stream model: mode 0 = bubble before presenting rom[m_p],
    // 1 = presenting rom[m_p], 2 = stopped on the halt word at m_p.
    int          m_mode = 0;
    logic [7:0]  m_p    = RST;
    logic [15:0] m_inst = '0;
    logic [7:0]  m_pc   = RST;

    always #5 clk = ~clk;

    inst_fetch #(.N(16), .AW(8), .RESET_PC(RST), .HALT_INST(H)) u_dut (
        .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_data(mem_data),
        .inst(inst), .inst_valid(inst_valid), .inst_ready(inst_ready),
        .pc(pc), .jmp(jmp), .jmp_addr(jmp_addr), .halted(halted)
    );

    inst_fetch #(.N(16), .AW(8), .RESET_PC(8'hFF), .HALT_INST(H)) u_dut_wrap (
        .clk(clk), .rst(rst2), .mem_addr(mem_addr2), .mem_data(mem_data2),
        .inst(inst2), .inst_valid(inst_valid2), .inst_ready(1'b1),
        .pc(pc2), .jmp(1'b0), .jmp_addr(8'h00), .halted(halted2)
    );

    always @(posedge clk) mem_data  <= rom[mem_addr];
    always @(posedge clk) mem_data2 <= rom2[mem_addr2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic fill_rom(input int halt_one_in);
        for (int i = 0; i < 256; i++) begin
            logic [15:0] w;
            w = 16'($urandom);
            if (w == H) w = 16'h0;
            if (halt_one_in > 0 && ($urandom % halt_one_in) == 0) w = H;
            rom[i] = w;
        end
    endtask

    task automatic load_prog();
        fill_rom(0);
        rom[0]  = 16'h1A2A;
        rom[1]  = 16'h1B03;
        rom[2]  = H;
        rom[16] = 16'h2ABC;
    endtask

    // One clock: drive inputs, compare outputs with the model, advance the model.
    task automatic step(input logic r, input logic j, input logic [7:0] ja, input logic rdy);
        logic [7:0] exp_ma, p1, p2;
        @(negedge clk);
        rst = r; jmp = j; jmp_addr = ja; inst_ready = rdy;
        #1;
        p1 = m_p + 8'd1;
        p2 = m_p + 8'd2;
        if (armed) begin
            if (r)                exp_ma = RST;
            else if (j)           exp_ma = ja;
            else if (m_mode == 0) exp_ma = (rom[m_p] == H) ? m_p : p1;
            else if (m_mode == 1) exp_ma = !rdy ? p1 : ((rom[p1] == H) ? p1 : p2);
            else                  exp_ma = m_p;
            chk("valid",    inst_valid, (m_mode == 1));
            chk("halted",   halted,     (m_mode == 2));
            chk("inst",     inst,       m_inst);
            chk("pc",       pc,         m_pc);
            chk("mem_addr", mem_addr,   exp_ma);
            if (verbose && inst_valid && rdy && !j && !r)
                $display("accept pc=%h inst=%h", pc, inst);
        end
        @(posedge clk);
        if (r) begin
            m_mode = 0; m_p = RST; m_inst = '0; m_pc = RST; armed = 1;
        end else if (j) begin
            m_mode = 0; m_p = ja;
        end else if (m_mode == 0) begin
            if (rom[m_p] == H) m_mode = 2;
            else begin m_mode = 1; m_inst = rom[m_p]; m_pc = m_p; end
        end else if (m_mode == 1 && rdy) begin
            m_p = p1;
            if (rom[p1] == H) m_mode = 2;
            else begin m_inst = rom[p1]; m_pc = p1; end
        end
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom2[i] = 16'h0100 + 16'(i);
        rom2[255] = 16'h0001;
        rom2[0]   = 16'h0002;
        rom2[1]   = 16'h0003;

        // Straight-line program into the halt word.
        verbose = 1;
        load_prog();
        step(1, 0, 0, 1);
        chk("rst_inst", inst, 16'h0); chk("rst_valid", inst_valid, 0); chk("rst_halted", halted, 0);
        step(0, 0, 0, 1);
        chk("A_inst0", inst, 16'h1A2A); chk("A_pc0", pc, 8'd0); chk("A_valid0", inst_valid, 1);
        step(0, 0, 0, 1);
        chk("A_inst1", inst, 16'h1B03); chk("A_pc1", pc, 8'd1);
        step(0, 0, 0, 1);
        chk("A_halted", halted, 1); chk("A_nvalid", inst_valid, 0); chk("A_maddr", mem_addr, 8'd2);
        step(0, 0, 0, 1);
        chk("A_maddr_hold", mem_addr, 8'd2);

        // Three-cycle stall on the first word.
        step(1, 0, 0, 1);
        step(0, 0, 0, 1);
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 0, 0);
            chk("B_inst", inst, 16'h1A2A); chk("B_pc", pc, 8'd0); chk("B_maddr", mem_addr, 8'd1);
        end
        step(0, 0, 0, 1);
        chk("B_next", inst, 16'h1B03); chk("B_next_pc", pc, 8'd1);

        // Jump together with ready: word dropped, one bubble.
        step(1, 0, 0, 1);
        step(0, 0, 0, 1);
        step(0, 1, 8'h10, 1);
        chk("C_bubble", inst_valid, 0);
        step(0, 0, 0, 1);
        chk("C_inst", inst, 16'h2ABC); chk("C_pc", pc, 8'd16); chk("C_valid", inst_valid, 1);

        // Jump out of halt.
        step(1, 0, 0, 1);
        repeat (3) step(0, 0, 0, 1);
        chk("D_halted", halted, 1);
        step(0, 1, 8'h00, 1);
        chk("D_unhalt", halted, 0); chk("D_bubble", inst_valid, 0);
        step(0, 0, 0, 1);
        chk("D_inst", inst, 16'h1A2A); chk("D_pc", pc, 8'd0);

        // Reset in the middle of the stream.
        step(1, 0, 0, 1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        chk("F_pc1", pc, 8'd1);
        step(1, 0, 0, 1);
        chk("F_rst_inst", inst, 16'h0); chk("F_rst_valid", inst_valid, 0); chk("F_rst_pc", pc, 8'd0);
        step(0, 0, 0, 1);
        chk("F_inst", inst, 16'h1A2A); chk("F_pc", pc, 8'd0); chk("F_valid", inst_valid, 1);
        verbose = 0;

        // Random traffic; the ROM only changes under reset.
        for (int it = 0; it < 4000; it++) begin
            if (it % 500 == 0) begin
                fill_rom(12);
                step(1, 0, 0, 1);
            end else begin
                step(($urandom % 200) == 0, ($urandom % 16) == 0,
                     8'($urandom), ($urandom % 10) < 7);
            end
        end

        // Address wrap with RESET_PC = 255.
        @(negedge clk);
        chk("W_rst_pc", pc2, 8'hFF); chk("W_rst_valid", inst_valid2, 0); chk("W_rst_maddr", mem_addr2, 8'hFF);
        rst2 = 1'b0;
        @(posedge clk); #1;
        chk("W_valid0", inst_valid2, 1); chk("W_pc0", pc2, 8'hFF); chk("W_inst0", inst2, 16'h0001);
        @(posedge clk); #1;
        chk("W_valid1", inst_valid2, 1); chk("W_pc1", pc2, 8'h00); chk("W_inst1", inst2, 16'h0002);
        @(posedge clk); #1;
        chk("W_pc2", pc2, 8'h01); chk("W_inst2", inst2, 16'h0003);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch stage that sits directly upstream of the 16-bit `cpu` core and drives its `inst` input. It owns the program counter, reads instruction words from a synchronous program ROM (one-cycle read latency), and presents them to the core through a valid/ready handshake. It also redirects on jumps from the core and stops on a halt word.

## Interface
- `N`, 16, instruction word width
- `AW`, 8, program address width
- `RESET_PC`, 0, first fetch address after reset
- `HALT_INST`, 16'hFFFF, word that stops fetching; it is never presented to the core

- `clk`  in  1  clock, all state updates on rising edge
- `rst`  in  1  reset; one clock, reset is synchronous and active-high
- `mem_addr`  out  AW  address the ROM samples at the coming edge (combinational)
- `mem_data`  in  N  ROM word for the address sampled at the previous edge
- `inst`  out  N  instruction presented to the core (registered)
- `inst_valid`  out  1  `inst` is a valid instruction
- `inst_ready`  in  1  core accepts `inst` this cycle
- `pc`  out  AW  address of the word in `inst` (registered)
- `jmp`  in  1  redirect request from the core
- `jmp_addr`  in  AW  redirect target
- `halted`  out  1  `HALT_INST` fetched; fetching stopped

## Operation
- Internal state: `nxt` (address whose word is on `mem_data`); FSM state FILL, RUN or HALT.
- Reset (edge with `rst`=1): state<=FILL, `nxt`<=RESET_PC, `inst`<=0, `pc`<=RESET_PC, `inst_valid`<=0, `halted`<=0. While `rst`=1, `mem_addr`=RESET_PC.
- "Capture": `inst`<=`mem_data`, `pc`<=`nxt`, `nxt`<=`nxt`+1, `mem_addr`=`nxt`+1. If `mem_data`==HALT_INST, capture is replaced by: state<=HALT, `inst_valid`<=0, `halted`<=1, `nxt` and `inst` unchanged, `mem_addr`=`nxt`.
- FILL: `inst_valid`=0. Capture unconditionally, then state<=RUN.
- RUN: `inst_valid`=1. If `inst_ready`=1, capture and stay in RUN. If `inst_ready`=0, hold `inst`, `pc` and `nxt`, with `mem_addr`=`nxt`.
- HALT: `inst_valid`=0, `halted`=1, `mem_addr`=`nxt`. The block leaves HALT only on `rst` or `jmp`.
- `jmp`=1 in any state overrides all of the above:
  - `mem_addr`=`jmp_addr`, `nxt`<=`jmp_addr`, state<=FILL, `inst_valid`<=0, `halted`<=0.
  - A presented `inst` is discarded even if `inst_ready`=1 in the same cycle.
- Priority: `rst` > `jmp` > halt detection > capture/hold.
- Arithmetic: `nxt`+1 is modulo 2^AW, so address 255 wraps to 0 with no flag.
- Outputs never carry X after the first reset edge.

## Timing
- Reset values: `inst`=0, `inst_valid`=0, `pc`=RESET_PC, `halted`=0, `mem_addr`=RESET_PC.
- Reset release: the first edge with `rst`=0 is in FILL. `inst_valid` rises after that edge with `inst`=mem[RESET_PC].
- Throughput: one instruction per cycle while `inst_ready`=1. No bubble between consecutive words.
- Stall: `inst`, `pc` and `mem_addr` are stable for every cycle `inst_ready`=0.
- Jump latency: if `jmp` is sampled at edge k, there is one bubble cycle after k. `inst_valid`=1 after edge k+1 with `pc`=`jmp_addr`.
- Halt: after the edge that captures HALT_INST, `inst_valid`=0 and `halted`=1 in the same cycle.
- Reset mid-stream or while halted: the next cycle shows reset values, and the sequence restarts from RESET_PC.

## Test plan
- ROM[0..2] = 16'h1A2A, 16'h1B03, 16'hFFFF, with `inst_ready`=1 -> valid words 1A2A (pc 0) then 1B03 (pc 1) on consecutive cycles; then `halted`=1, `inst_valid`=0 and `mem_addr` held at 2.
- Same program with `inst_ready` low for 3 cycles while 1A2A is presented -> `inst`=1A2A, `pc`=0 and `mem_addr`=1 are stable for 3 cycles; 1B03 follows one cycle after ready returns.
- `jmp`=1, `jmp_addr`=8'h10 (ROM[16]=16'h2ABC) asserted together with `inst_ready`=1 -> the current word is dropped, there is one bubble, then `inst`=2ABC with `pc`=16.
- While halted, `jmp` to 0 -> `halted` clears and 1A2A is re-presented after one bubble.
- RESET_PC=255, ROM[255]=16'h0001, ROM[0]=16'h0002 -> `pc` reads 255 then 0, with no stall at the wrap.
- `rst` pulsed for one cycle while in RUN at pc 1 -> reset values next cycle, then 1A2A (pc 0) is valid one cycle after reset release.
